// File: rtl/criq_alloc_sched.sv
`default_nettype none
// criq_alloc_sched: arbitrates two rename slots for free tags, tracks the free-tag count
// and sequences the circular free-tag queue's read/write/clean controls across flush.
module criq_alloc_sched #(
   parameter int TAGW  = 5,
   parameter int DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0_i,
   input  logic            req1_i,
   output logic            gnt0_o,
   output logic            gnt1_o,
   output logic            tag_vld_o,
   output logic            tag_port_o,
   output logic [TAGW-1:0] tag_out_o,
   input  logic            ret_vld_i,
   input  logic [TAGW-1:0] ret_tag_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            ovf_err_o,
   output logic            q_rable_o,
   output logic            q_wable_o,
   output logic            q_clean_o,
   output logic [TAGW-1:0] q_din_o,
   input  logic [TAGW-1:0] q_dout_i
);

   localparam int CNTW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_RECOV = 2'd1,
      S_RUN   = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [CNTW-1:0] count_q, count_d;
   logic            prio_q, prio_d;
   logic            ovf_q, ovf_d;
   logic            tag_vld_q, tag_port_q;

   logic run_ok, elig, gnt0, gnt1, gnt_any, ret_acc, ovf_hit;

   assign run_ok  = (state_q == S_RUN) && !flush_i;
   assign elig    = run_ok && (count_q != '0);
   // Contested cycles go to the Prio slot; an uncontested request always wins.
   assign gnt0    = elig && req0_i && (!req1_i || !prio_q);
   assign gnt1    = elig && req1_i && (!req0_i ||  prio_q);
   assign gnt_any = gnt0 | gnt1;
   assign ret_acc = ret_vld_i && run_ok && (count_q != CNTW'(DEPTH));
   assign ovf_hit = ret_vld_i && run_ok && (count_q == CNTW'(DEPTH));

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      prio_d  = prio_q;
      ovf_d   = ovf_q | ovf_hit;
      case (state_q)
         S_INIT: begin
            state_d = S_RECOV;
            count_d = CNTW'(DEPTH);
         end
         S_RECOV: state_d = flush_i ? S_INIT : S_RUN;
         S_RUN: begin
            if (flush_i) begin
               state_d = S_INIT;
            end else begin
               if (gnt_any && !ret_acc)
                  count_d = count_q - CNTW'(1);
               else if (ret_acc && !gnt_any)
                  count_d = count_q + CNTW'(1);
               // After any grant the pointer favours the slot that was not served.
               if (gnt_any)
                  prio_d = gnt0;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_INIT;
         count_q    <= CNTW'(DEPTH);
         prio_q     <= 1'b0;
         ovf_q      <= 1'b0;
         tag_vld_q  <= 1'b0;
         tag_port_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         prio_q     <= prio_d;
         ovf_q      <= ovf_d;
         tag_vld_q  <= gnt_any;
         tag_port_q <= gnt1;
      end
   end

   assign gnt0_o     = gnt0;
   assign gnt1_o     = gnt1;
   assign stall_o    = !elig;
   assign tag_vld_o  = tag_vld_q;
   assign tag_port_o = tag_port_q;
   assign tag_out_o  = q_dout_i;
   assign ovf_err_o  = ovf_q;
   assign q_rable_o  = gnt_any;
   assign q_wable_o  = ret_acc;
   assign q_clean_o  = (state_q == S_INIT);
   assign q_din_o    = ret_tag_i;

endmodule
`default_nettype wire

// File: tb/tb_criq_alloc_sched.sv
`default_nettype none
// tb_criq_alloc_sched: directed and randomized checks of the allocation scheduler against
// a free-list reference model, with a behavioural free-tag queue supplying Dout.
module tb_criq_alloc_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0, ret_vld = 1'b0, flush = 1'b0;
   logic [4:0] ret_tag = '0;
   logic       gnt0, gnt1, tag_vld, tag_port, stall, ovf_err;
   logic       q_rable, q_wable, q_clean;
   logic [4:0] tag_out, q_din;
   logic [4:0] q_dout;

   int n_asrt = 0;
   int n_fail = 0;

   criq_alloc_sched #(.TAGW(5), .DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_i(req0), .req1_i(req1),
      .gnt0_o(gnt0), .gnt1_o(gnt1),
      .tag_vld_o(tag_vld), .tag_port_o(tag_port), .tag_out_o(tag_out),
      .ret_vld_i(ret_vld), .ret_tag_i(ret_tag), .flush_i(flush),
      .stall_o(stall), .ovf_err_o(ovf_err),
      .q_rable_o(q_rable), .q_wable_o(q_wable), .q_clean_o(q_clean),
      .q_din_o(q_din), .q_dout_i(q_dout)
   );

   always #5 clk = ~clk;

   // Behavioural free-tag queue: registered Dout on read, append on write, reload on clean.
   int qm[$];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qm = {1, 5, 9, 13, 17, 21, 25, 29};
         q_dout <= 5'd0;
      end else if (q_clean) begin
         qm = {1, 5, 9, 13, 17, 21, 25, 29};
      end else begin
         if (q_rable) q_dout <= (qm.size() > 0) ? 5'(qm.pop_front()) : 5'd0;
         if (q_wable) qm.push_back(int'(q_din));
      end
   end

   // Reference model: phase 0 = cleaning, 1 = settling, 2 = running.
   int   phase;
   int   free_list[$];
   int   out_list[$];
   bit   last_srv;
   bit   e_vld, e_port, e_ovf;
   int   e_tag;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      phase     = 0;
      free_list = {1, 5, 9, 13, 17, 21, 25, 29};
      out_list  = {};
      last_srv  = 1'b1;
      e_vld     = 1'b0;
      e_port    = 1'b0;
      e_ovf     = 1'b0;
      e_tag     = 0;
   endtask

   task automatic reset_checks();
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_gnt1", 32'(gnt1), 32'd0);
      chk("rst_stall", 32'(stall), 32'd1);
      chk("rst_qrable", 32'(q_rable), 32'd0);
      chk("rst_qwable", 32'(q_wable), 32'd0);
      chk("rst_tagvld", 32'(tag_vld), 32'd0);
      chk("rst_tagport", 32'(tag_port), 32'd0);
      chk("rst_ovf", 32'(ovf_err), 32'd0);
      chk("rst_qclean", 32'(q_clean), 32'd1);
   endtask

   task automatic step(input bit r0, input bit r1, input bit rv, input int rt, input bit fl,
                       output bit g0o, output bit g1o);
      bit run_ok, elig, w0, w1, acc, ov;
      @(negedge clk);
      req0 = r0; req1 = r1; ret_vld = rv; ret_tag = 5'(rt); flush = fl;
      #1;
      run_ok = (phase == 2) && !fl;
      elig   = run_ok && (free_list.size() > 0);
      w0     = elig && r0 && (!r1 || last_srv);
      w1     = elig && r1 && (!r0 || !last_srv);
      acc    = rv && run_ok && (free_list.size() < 8);
      ov     = rv && run_ok && (free_list.size() == 8);
      chk("gnt0", 32'(gnt0), 32'(w0));
      chk("gnt1", 32'(gnt1), 32'(w1));
      chk("stall", 32'(stall), 32'(!elig));
      chk("qrable", 32'(q_rable), 32'(w0 | w1));
      chk("qwable", 32'(q_wable), 32'(acc));
      if (acc) chk("qdin", 32'(q_din), 32'(rt));
      chk("qclean", 32'(q_clean), 32'(phase == 0));
      chk("tagvld", 32'(tag_vld), 32'(e_vld));
      if (e_vld) begin
         chk("tagport", 32'(tag_port), 32'(e_port));
         chk("tagout", 32'(tag_out), 32'(e_tag));
      end
      chk("ovferr", 32'(ovf_err), 32'(e_ovf));
      g0o = gnt0; g1o = gnt1;
      @(posedge clk);
      e_vld = w0 | w1;
      if (w0 | w1) begin
         e_tag    = free_list.pop_front();
         e_port   = w1;
         last_srv = w1;
         out_list.push_back(e_tag);
      end
      if (acc) free_list.push_back(rt);
      if (ov) e_ovf = 1'b1;
      case (phase)
         0: begin
            phase     = 1;
            free_list = {1, 5, 9, 13, 17, 21, 25, 29};
            out_list  = {};
         end
         default: phase = fl ? 0 : 2;
      endcase
   endtask

   initial begin
      bit g0, g1, hr0, hr1;
      int idx, rt;
      bit rv;

      // Reset state, then Req0 held: tags 1,5,...,29 in order, stall on the 9th request.
      model_reset();
      ret_vld = 1'b1; req0 = 1'b1;
      #12;
      reset_checks();
      ret_vld = 1'b0; req0 = 1'b0;
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (2) step(1, 0, 0, 0, 0, g0, g1);
      repeat (9) step(1, 0, 0, 0, 0, g0, g1);
      step(0, 0, 0, 0, 0, g0, g1);

      // Empty queue: same-cycle return yields no grant; the grant comes one cycle later.
      step(0, 1, 1, 9, 0, g0, g1);
      chk("ret_no_gnt", 32'(g1), 32'd0);
      step(0, 1, 0, 0, 0, g0, g1);
      chk("ret_then_gnt", 32'(g1), 32'd1);
      step(0, 0, 0, 0, 0, g0, g1);

      // Flush restores all tags; mid-stream flush after 3 grants.
      step(0, 0, 0, 0, 1, g0, g1);
      repeat (2) step(0, 0, 0, 0, 0, g0, g1);
      repeat (3) step(1, 1, 0, 0, 0, g0, g1);
      step(1, 1, 0, 0, 1, g0, g1);
      repeat (2) step(1, 1, 0, 0, 0, g0, g1);
      step(1, 0, 0, 0, 0, g0, g1);
      step(0, 0, 0, 0, 0, g0, g1);

      // Return tag 1 brings count to 8; a further return overflows and stays sticky.
      step(0, 0, 1, 1, 0, g0, g1);
      step(0, 0, 1, 3, 0, g0, g1);
      repeat (3) step(0, 0, 0, 0, 0, g0, g1);

      // Asynchronous reset during a grant burst, then both requesters held from reset.
      repeat (3) step(1, 1, 0, 0, 0, g0, g1);
      @(posedge clk); #2;
      rst_n = 1'b0; ret_vld = 1'b1;
      #1;
      reset_checks();
      model_reset();
      ret_vld = 1'b0;
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (8) step(1, 1, 0, 0, 0, g0, g1);
      step(0, 0, 0, 0, 0, g0, g1);

      // Randomized traffic with hold-until-grant requesters, returns and occasional flush.
      hr0 = 1'b0; hr1 = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if (!hr0) hr0 = ($urandom_range(0, 2) != 0);
         if (!hr1) hr1 = ($urandom_range(0, 2) != 0);
         rv = 1'b0; rt = 0;
         if (out_list.size() > 0 && $urandom_range(0, 2) == 0) begin
            idx = $urandom_range(0, out_list.size() - 1);
            rt  = out_list[idx];
            out_list.delete(idx);
            rv  = 1'b1;
         end else if ($urandom_range(0, 99) == 0) begin
            rv = 1'b1; rt = 7;
         end
         step(hr0, hr1, rv, rt, ($urandom_range(0, 49) == 0), g0, g1);
         if (g0) hr0 = 1'b0;
         if (g1) hr1 = 1'b0;
      end
      step(0, 0, 0, 0, 0, g0, g1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
